// File: rtl/mult32_seq.sv
// Sequential unsigned shift-add multiplier, one partial product per clock.
// Start/busy/done handshake; product holds the last completed result.
module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
  logic                 last;

  // One partial-product add with carry kept, then shift {sum,mplier} right.
  assign sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {sum, mplier_q[WIDTH-1:1]};
  assign last    = (count_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, iterate in RUN.
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    if (state_q == IDLE && start) begin
      mcand_d  = a;
      acc_d    = '0;
      mplier_d = b;
      count_d  = '0;
    end else if (state_q == RUN) begin
      acc_d    = shifted[2*WIDTH-1:WIDTH];
      mplier_d = shifted[WIDTH-1:0];
      count_d  = count_q + 1'b1;
      if (last) product_d = shifted;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Directed self-checking bench for mult32_seq.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;
  int n;

  mult32_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an edge with busy high; returns busy cycles seen.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
    int c;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(c);
    chk({tag, "_cycles"}, 64'(c), 64'd32);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_prod"}, product, exp);
    @(negedge clk);
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mult("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F);

    // Zero result, with a start pulse during RUN that must be ignored.
    @(negedge clk);
    a = 32'd0; b = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_hold", product, 64'h0000_0000_0000_000F);
    wait_done(n);
    chk("zero_cycles", 64'(n), 64'd22);
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_prod", product, 64'd0);
    @(negedge clk);
    chk("zero_done_low", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_no_requeue", {63'd0, busy | done}, 64'd0);

    run_mult("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             64'hFFFF_FFFE_0000_0001);
    run_mult("carry", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 32'd10; b = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("rst_mid_pre", product, 64'h0000_0001_0000_0000);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_idle", {63'd0, busy | done}, 64'd0);
    run_mult("after_rst", 32'd10, 32'd10, 64'd100);

    // Back-to-back with start held high; operand change during RUN.
    @(negedge clk);
    a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    chk("b2b_busy1", {63'd0, busy}, 64'd1);
    a = 32'd9; b = 32'd9;
    wait_done(n);
    chk("b2b_cycles1", 64'(n), 64'd32);
    chk("b2b_done1", {63'd0, done}, 64'd1);
    chk("b2b_prod1", product, 64'd42);
    @(negedge clk);
    chk("b2b_gap", {63'd0, busy | done}, 64'd0);
    @(negedge clk);
    chk("b2b_busy2", {63'd0, busy}, 64'd1);
    start = 1'b0;
    chk("b2b_hold_a", product, 64'd42);
    repeat (10) @(negedge clk);
    chk("b2b_hold_b", product, 64'd42);
    wait_done(n);
    chk("b2b_cycles2", 64'(n), 64'd22);
    chk("b2b_done2", {63'd0, done}, 64'd1);
    chk("b2b_prod2", product, 64'd81);
    @(negedge clk);
    chk("b2b_end", {63'd0, busy | done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
